// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - game state encoding and score/speed constants shared with the score tracker
package snake_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      OVER  = 2'd3
   } game_state_t;

   localparam int SNAKE_MAX_SCORE       = 100;
   localparam int SNAKE_BASE_PERIOD     = 16;
   localparam int SNAKE_STEP_DEC        = 2;
   localparam int SNAKE_MIN_PERIOD      = 4;
   localparam int SNAKE_SCORE_PER_LEVEL = 5;
   localparam int SNAKE_LEVEL_MAX       = 7;

endpackage

// File: rtl/snake_move_timer.sv
// rtl/snake_move_timer.sv - loadable down-counter with freeze and registered terminal-count pulse
module snake_move_timer #(
   parameter int W = 4,
   parameter logic [W-1:0] INIT = '1
) (
   input  logic         clk,
   input  logic         nRst,
   input  logic         clear_i,
   input  logic         run_i,
   input  logic [W-1:0] reload_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         tc_d;

   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      if (clear_i) begin
         cnt_d = INIT;
      end else if (run_i) begin
         if (cnt_q == '0) begin
            cnt_d = reload_i;
            tc_d  = 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt_q <= INIT;
         tc_o  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_o  <= tc_d;
      end
   end

endmodule

// File: rtl/snake_game_sequencer.sv
// rtl/snake_game_sequencer.sv - snake game lifecycle, move pacing and collision pulses
// Optional PAUSE state is built only when SNAKE_PAUSE_EN is defined.
module snake_game_sequencer
   import snake_pkg::*;
#(
   parameter int BASE_PERIOD     = SNAKE_BASE_PERIOD,
   parameter int STEP_DEC        = SNAKE_STEP_DEC,
   parameter int MIN_PERIOD      = SNAKE_MIN_PERIOD,
   parameter int SCORE_PER_LEVEL = SNAKE_SCORE_PER_LEVEL,
   parameter int LEVEL_MAX       = SNAKE_LEVEL_MAX,
   parameter int MAX_SCORE       = SNAKE_MAX_SCORE
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       startBtn,
   input  logic       pauseBtn,
   input  logic       appleHit,
   input  logic       wallHit,
   input  logic       selfHit,
   input  logic [6:0] currScore,
   output logic       moveTick,
   output logic       goodColl,
   output logic       badColl,
   output logic [1:0] gameState,
   output logic [2:0] speedLevel,
   output logic       win
);

   localparam int         TW          = $clog2(BASE_PERIOD);
   localparam logic [6:0] MAX_SCORE_W = 7'(MAX_SCORE);

   game_state_t   state_q, state_d;
   logic [2:0]    speed_q, speed_d;
   logic          good_q, good_d, bad_q, bad_d, win_q, win_d;
   logic          check_q, start_prev_q, start_edge;
   logic          run, clear;
   logic [TW-1:0] reload;

   function automatic logic [2:0] level_of(logic [6:0] score);
      int lvl;
      lvl = int'(score) / SCORE_PER_LEVEL;
      if (lvl > LEVEL_MAX) lvl = LEVEL_MAX;
      return 3'(lvl);
   endfunction

   // Clamp before subtracting so large levels never wrap the period.
   function automatic logic [TW-1:0] reload_of(logic [2:0] lvl);
      int dec;
      dec = int'(lvl) * STEP_DEC;
      if (dec >= BASE_PERIOD - MIN_PERIOD) return TW'(MIN_PERIOD - 1);
      return TW'(BASE_PERIOD - dec - 1);
   endfunction

   assign start_edge = startBtn & ~start_prev_q;
   assign speed_d    = level_of(currScore);
   assign reload     = reload_of(speed_q);

`ifdef SNAKE_PAUSE_EN
   logic pause_prev_q, pause_edge, pend_q, pend_d;
   assign pause_edge = pauseBtn & ~pause_prev_q;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         pause_prev_q <= 1'b1;
         pend_q       <= 1'b0;
      end else begin
         pause_prev_q <= pauseBtn;
         pend_q       <= pend_d;
      end
   end
`else
   logic unused_pause;
   assign unused_pause = pauseBtn;
`endif

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      good_d  = 1'b0;
      bad_d   = 1'b0;
      run     = 1'b0;
      clear   = 1'b0;
`ifdef SNAKE_PAUSE_EN
      pend_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            clear = 1'b1;
            win_d = 1'b0;
            if (start_edge) state_d = RUN;
         end
         RUN: begin
            run = 1'b1;
            if (currScore >= MAX_SCORE_W) begin
               state_d = OVER;
               win_d   = 1'b1;
               run     = 1'b0;
            end else if (check_q) begin
               if (wallHit | selfHit) begin
                  bad_d   = 1'b1;
                  state_d = OVER;
                  win_d   = 1'b0;
                  run     = 1'b0;
               end else begin
                  good_d = appleHit;
`ifdef SNAKE_PAUSE_EN
                  if (pause_edge | pend_q) begin
                     state_d = PAUSE;
                     run     = 1'b0;
                  end
`endif
               end
            end
`ifdef SNAKE_PAUSE_EN
            // A pause arriving with a tick still owes that tick its check cycle.
            else if (pause_edge) begin
               if (moveTick) begin
                  pend_d = 1'b1;
               end else begin
                  state_d = PAUSE;
                  run     = 1'b0;
               end
            end
`endif
         end
`ifdef SNAKE_PAUSE_EN
         PAUSE: begin
            if (pause_edge) state_d = RUN;
         end
`endif
         default: begin
            clear = 1'b1;
            if (start_edge) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q      <= IDLE;
         speed_q      <= 3'd0;
         good_q       <= 1'b0;
         bad_q        <= 1'b0;
         win_q        <= 1'b0;
         check_q      <= 1'b0;
         start_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         speed_q      <= speed_d;
         good_q       <= good_d;
         bad_q        <= bad_d;
         win_q        <= win_d;
         check_q      <= moveTick;
         start_prev_q <= startBtn;
      end
   end

   snake_move_timer #(
      .W    (TW),
      .INIT (TW'(BASE_PERIOD - 1))
   ) u_timer (
      .clk      (clk),
      .nRst     (nRst),
      .clear_i  (clear),
      .run_i    (run),
      .reload_i (reload),
      .tc_o     (moveTick)
   );

   assign goodColl   = good_q;
   assign badColl    = bad_q;
   assign gameState  = state_q;
   assign speedLevel = speed_q;
   assign win        = win_q;

endmodule
